tape_rec_capture: RTL and testbench

//  Captures the CPC cassette-write signal (tape_rec) while the tape motor runs and encodes

---
 rtl/tape_rec_capture_pkg.sv | 12 +
 rtl/tape_rec_capture_if.sv | 9 +
 rtl/tape_rec_capture_fifo.sv | 47 ++++
 rtl/tape_rec_capture.sv | 117 +++++++++++
 tb/tb_tape_rec_capture.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/tape_rec_capture_pkg.sv
// Shared types and constants for the cassette-record CSW encoder.
package tape_capture_pkg;
  typedef enum logic [2:0] {IDLE, SHORT, Z, L0, L1, L2, L3} state_e;

  localparam logic [7:0]  CSW_LONG_MARK = 8'h00;
  localparam int unsigned CSW_SHORT_MAX = 255;

  // Number of FIFO bytes a committed run occupies.
  function automatic logic [31:0] rec_len(input logic [31:0] len);
    return (len > 32'(CSW_SHORT_MAX)) ? 32'd5 : 32'd1;
  endfunction
endpackage

// File: rtl/tape_rec_capture_if.sv
// Byte stream from the capture FIFO to the host-upload path.
interface tape_rec_capture_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, out_valid, input out_ready);
  modport slave  (input out_data, out_valid, output out_ready);
endinterface

// File: rtl/tape_rec_capture_fifo.sv
// Show-ahead synchronous FIFO; head word is always visible on dout_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     free_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign free_o  = (AW+1)'(DEPTH) - cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so push into a full FIFO is fine then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/tape_rec_capture.sv
// Records tape_rec pulse lengths while the motor runs and emits them as CSW v1 RLE bytes.
module tape_rec_capture
  import tape_capture_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_sample,
  input  logic                    tape_rec,
  input  logic                    tape_motor,
  tape_rec_capture_if.master      up,
  output logic                    active,
  output logic                    overflow,
  output logic [31:0]             byte_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] rec_sync_q, mot_sync_q;
  logic                   mot_prev_q, rec_s, mot_s, mot_rise, mot_fall;
  logic                   ref_q, ref_d;
  logic [31:0]            run_len_q, run_len_d, len_q, byte_count_q;
  logic                   commit, accept, overflow_q;
  state_e                 state_q, state_d;
  logic                   push;
  logic [7:0]             push_data;
  logic                   fifo_full, fifo_empty;
  logic [AW:0]            fifo_free;

  assign rec_s    = rec_sync_q[SYNC_STAGES-1];
  assign mot_s    = mot_sync_q[SYNC_STAGES-1];
  assign mot_rise = mot_s & ~mot_prev_q;
  assign mot_fall = ~mot_s & mot_prev_q;

  always_comb begin
    run_len_d = run_len_q;
    ref_d     = ref_q;
    commit    = 1'b0;
    if (mot_rise) begin
      ref_d     = rec_s;
      run_len_d = '0;
    end else if (mot_fall) begin
      commit    = (run_len_q != '0);
      run_len_d = '0;
    end else if (ce_sample && mot_s) begin
      if (rec_s == ref_q) begin
        if (run_len_q != '1) run_len_d = run_len_q + 32'd1;
      end else begin
        commit    = (run_len_q != '0);
        ref_d     = rec_s;
        run_len_d = 32'd1;
      end
    end
  end

  // Whole record must fit now; a partial record is never started.
  assign accept = commit && (state_q == IDLE) && !fifo_full &&
                  (32'(fifo_free) >= rec_len(run_len_q));

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = len_q[7:0];
    case (state_q)
      IDLE:  if (accept) state_d = (rec_len(run_len_q) == 32'd5) ? Z : SHORT;
      SHORT: begin push = 1'b1; state_d = IDLE; end
      Z:     begin push = 1'b1; push_data = CSW_LONG_MARK; state_d = L0; end
      L0:    begin push = 1'b1; state_d = L1; end
      L1:    begin push = 1'b1; push_data = len_q[15:8];  state_d = L2; end
      L2:    begin push = 1'b1; push_data = len_q[23:16]; state_d = L3; end
      L3:    begin push = 1'b1; push_data = len_q[31:24]; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rec_sync_q   <= '0;
      mot_sync_q   <= '0;
      mot_prev_q   <= 1'b0;
      ref_q        <= 1'b0;
      run_len_q    <= '0;
      len_q        <= '0;
      state_q      <= IDLE;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      rec_sync_q   <= {rec_sync_q[SYNC_STAGES-2:0], tape_rec};
      mot_sync_q   <= {mot_sync_q[SYNC_STAGES-2:0], tape_motor};
      mot_prev_q   <= mot_s;
      ref_q        <= ref_d;
      run_len_q    <= run_len_d;
      state_q      <= state_d;
      if (accept) len_q <= run_len_q;
      if (commit && !accept) overflow_q <= 1'b1;
      byte_count_q <= byte_count_q + 32'(push);
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (up.out_ready),
    .dout_o  (up.out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  assign up.out_valid = ~fifo_empty;
  assign active       = mot_s | (state_q != IDLE);
  assign overflow     = overflow_q;
  assign byte_count   = byte_count_q;
endmodule

// File: tb/tb_tape_rec_capture.sv
// Directed checks of the CSW record encoder: short/long runs, backpressure, overflow, reset.
module tb_tape_rec_capture;
  import tape_capture_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1, ce_sample = 1'b0, tape_rec = 1'b0, tape_motor = 1'b0;
  logic        active, overflow;
  logic [31:0] byte_count;
  int          n_asrt = 0, n_fail = 0;

  tape_rec_capture_if bus();

  tape_rec_capture #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_sample  (ce_sample),
    .tape_rec   (tape_rec),
    .tape_motor (tape_motor),
    .up         (bus),
    .active     (active),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      ce_sample = 1'b1;
      tick();
      ce_sample = 1'b0;
      repeat (9) tick();
    end
  endtask

  task automatic toggle();
    tape_rec = ~tape_rec;
    repeat (4) tick();
  endtask

  task automatic motor(input logic v);
    tape_motor = v;
    repeat (10) tick();
  endtask

  task automatic pop_chk(input logic [7:0] exp, input string tag);
    chk(32'(bus.out_valid), 32'd1, {tag, "_valid"});
    chk(32'(bus.out_data), 32'(exp), tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk(32'(bus.out_valid), 0, "rst_valid");
    chk(32'(active), 0, "rst_active");
    chk(32'(overflow), 0, "rst_overflow");
    chk(byte_count, 0, "rst_byte_count");

    // Four toggles every 10 samples, then the motor drops on a 10-sample run
    motor(1'b1);
    samples(10);
    repeat (4) begin toggle(); samples(10); end
    motor(1'b0);
    chk(byte_count, 5, "t1_byte_count");
    for (int i = 0; i < 5; i++) pop_chk(8'h0A, "t1_byte");
    chk(32'(bus.out_valid), 0, "t1_drained");

    // 300 = 0x12C needs the long form; head must hold while not accepted
    motor(1'b1);
    samples(300);
    toggle();
    samples(1);
    chk(32'(bus.out_valid), 1, "t2_hold_valid0");
    chk(32'(bus.out_data), 32'h00, "t2_hold_data0");
    repeat (3) tick();
    chk(32'(bus.out_valid), 1, "t2_hold_valid1");
    chk(32'(bus.out_data), 32'h00, "t2_hold_data1");
    pop_chk(8'h00, "t2_b0");
    pop_chk(8'h2C, "t2_b1");
    pop_chk(8'h01, "t2_b2");
    pop_chk(8'h00, "t2_b3");
    pop_chk(8'h00, "t2_b4");
    chk(byte_count, 10, "t2_byte_count");

    // Motor falls 3 samples into a run; idle motor ignores the level
    samples(2);
    motor(1'b0);
    chk(byte_count, 11, "t4_byte_count");
    pop_chk(8'h03, "t4_trailing");
    toggle(); samples(3); toggle(); samples(2);
    chk(32'(bus.out_valid), 0, "t4_idle_valid");
    chk(32'(active), 0, "t4_idle_active");
    chk(byte_count, 11, "t4_idle_count");

    // Three 256-sample records fill 15 of 16 bytes; the fourth cannot fit
    motor(1'b1);
    samples(256);
    repeat (3) begin toggle(); samples(256); end
    chk(byte_count, 26, "t3_three_long");
    chk(32'(overflow), 0, "t3_no_ovf_yet");
    toggle(); samples(1);
    chk(32'(overflow), 1, "t3_ovf_set");
    chk(byte_count, 26, "t3_dropped");
    toggle(); samples(1);
    chk(byte_count, 27, "t3_short_fits");
    for (int r = 0; r < 3; r++) begin
      pop_chk(8'h00, "t3_mark");
      pop_chk(8'h00, "t3_l0");
      pop_chk(8'h01, "t3_l1");
      pop_chk(8'h00, "t3_l2");
      pop_chk(8'h00, "t3_l3");
    end
    pop_chk(8'h01, "t3_short");
    chk(32'(bus.out_valid), 0, "t3_drained");
    chk(32'(overflow), 1, "t3_ovf_sticky");

    // Run counter pinned near the top must saturate, not wrap
    force dut.run_len_q = 32'hFFFF_FFFE;
    tick(); tick();
    release dut.run_len_q;
    samples(2);
    toggle();
    samples(1);
    pop_chk(8'h00, "t6_mark");
    pop_chk(8'hFF, "t6_l0");
    pop_chk(8'hFF, "t6_l1");
    pop_chk(8'hFF, "t6_l2");
    pop_chk(8'hFF, "t6_l3");
    chk(byte_count, 32, "t6_byte_count");

    // Reset lands while the encoder is part-way through a long record
    samples(256);
    toggle();
    ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
    tick();
    tick();
    chk(32'(dut.state_q), 32'(L1), "t5_in_l1");
    chk(32'(bus.out_valid), 1, "t5_partial_valid");
    reset = 1'b1;
    tick();
    chk(32'(bus.out_valid), 0, "t5_valid");
    chk(byte_count, 0, "t5_byte_count");
    chk(32'(overflow), 0, "t5_overflow");
    chk(32'(dut.state_q), 32'(IDLE), "t5_state");
    chk(32'(active), 0, "t5_active");
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
